mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 8, memory address width; DATA_W, default 8, memory data width; STARVE_MAX, default 3, wait cycles after which requester 1 overrides requester 0 (legal 1..15).
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning. Requester 0 is the cpu; requester 1 is the loader/DMA.
- clk  in  1  single clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset
- req0 / req1  in  1  access request, held until granted
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  ADDR_W  access address
- wdata0 / wdata1  in  DATA_W  write data
- gnt0 / gnt1  out  1  access accepted this cycle
- rvalid0 / rvalid1  out  1  read data valid
- rdata0 / rdata1  out  DATA_W  read data
- operation  out  1  memory op, 1 = write
- memory_address  out  ADDR_W  memory address
- memory_input  out  DATA_W  memory write data
- memory_value  in  DATA_W  memory read data, valid one cycle after address
- busy  out  1  a grant or a read response is active this cycle

Function
REQ-003 Arbitration SHALL be combinational each cycle; at most one of gnt0/gnt1 SHALL be high.
REQ-004 A transfer SHALL complete in the cycle where reqN && gntN; requesters SHALL hold weN/addrN/wdataN stable while reqN is high and gntN is low.
REQ-005 Priority: req0 only -> gnt0; req1 only -> gnt1; both -> gnt0, unless wait1 == STARVE_MAX, in which case gnt1.
REQ-006 The 4-bit counter wait1 SHALL increment each cycle with req1 && !gnt1, saturating at STARVE_MAX, and SHALL clear to 0 on gnt1 or when req1 is low.
REQ-007 In a grant cycle, operation/memory_address/memory_input SHALL equal the granted weN/addrN/wdataN. With no grant they SHALL be 0/0/0, so no write occurs.
REQ-008 A granted read in cycle N SHALL produce rvalidN = 1 in cycle N+1 only, with rdataN = memory_value; a granted write SHALL produce no rvalid.
REQ-009 rdata0/rdata1 SHALL be 0 whenever the matching rvalid is low.
REQ-010 A read response register SHALL record the requester index and the read flag; back-to-back grants SHALL sustain one transfer per cycle; responses SHALL never overlap.
REQ-011 busy SHALL equal gnt0 | gnt1 | rvalid0 | rvalid1.
REQ-012 Write followed by read to the same address on consecutive cycles SHALL return the new data, ordered by memory timing.

Reset
REQ-013 reset low SHALL immediately force gnt0, gnt1, rvalid0, rvalid1, operation, busy = 0 and memory_address, memory_input, rdata0, rdata1 = 0, independent of clk.
REQ-014 reset low SHALL clear wait1 and the read response register; a read granted in the cycle before reset SHALL produce no rvalid.
REQ-015 After reset rises, arbitration SHALL resume on the next rising edge with wait1 = 0.

Verification
REQ-016 req0 read addr 0x10 (memory holds 0x5A), req1 low -> gnt0 in cycle 0; rvalid0 = 1 and rdata0 = 0x5A in cycle 1; rvalid1 stays 0.
REQ-017 req1 write 0x33 to addr 0x20, then read 0x20 -> gnt1 in two consecutive cycles; operation = 1 then 0; rvalid1 = 1 with rdata1 = 0x33 in the third cycle.
REQ-018 req0 and req1 held high continuously, STARVE_MAX = 3 -> gnt0 in cycles 0, 1, 2; gnt1 in cycle 3; pattern repeats every 4 cycles; no cycle has both grants.
REQ-019 req1 drops in cycle 2 while waiting and is reasserted in cycle 3 -> wait1 restarts from 0; first gnt1 in cycle 6 with req0 held high.
REQ-020 reset pulsed low in the cycle after a req0 read grant -> rvalid0 stays 0; all outputs are 0 while low; normal grants resume after release.
REQ-021 No requests for 5 cycles -> operation = 0, busy = 0, memory_address = 0 throughout.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port memory.
// The arbiter is the slave side; the requester/memory environment is the master side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              operation;
    logic [ADDR_W-1:0] memory_address;
    logic [DATA_W-1:0] memory_input;
    logic [DATA_W-1:0] memory_value;
    logic              busy;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, memory_value,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
               operation, memory_address, memory_input, busy
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, memory_value,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
               operation, memory_address, memory_input, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single-port memory with one-cycle read latency.
// The cpu (0) has priority; the loader (1) wins once it has waited STARVE_MAX cycles.
module mem_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    // Out-of-range settings are clamped so the 4-bit wait counter can always reach the limit.
    localparam int STARVE_CLAMP = (STARVE_MAX < 1) ? 1 : ((STARVE_MAX > 15) ? 15 : STARVE_MAX);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_CLAMP);

    logic              gnt0_c;
    logic              gnt1_c;
    logic              op_c;
    logic [ADDR_W-1:0] addr_c;
    logic [DATA_W-1:0] wdata_c;

    logic [3:0]        wait1_q;
    logic [3:0]        wait1_d;
    logic              rsp_valid_q;
    logic              rsp_valid_d;
    logic              rsp_idx_q;
    logic              rsp_idx_d;

    logic              rvalid0_c;
    logic              rvalid1_c;

    // Reset gates the grants directly so every grant-derived output drops without a clock.
    always_comb begin
        gnt0_c = 1'b0;
        gnt1_c = 1'b0;
        if (reset) begin
            if (bus.req1 && (!bus.req0 || (wait1_q == STARVE_LIM))) begin
                gnt1_c = 1'b1;
            end else if (bus.req0) begin
                gnt0_c = 1'b1;
            end
        end
    end

    always_comb begin
        op_c    = 1'b0;
        addr_c  = '0;
        wdata_c = '0;
        if (gnt0_c) begin
            op_c    = bus.we0;
            addr_c  = bus.addr0;
            wdata_c = bus.wdata0;
        end else if (gnt1_c) begin
            op_c    = bus.we1;
            addr_c  = bus.addr1;
            wdata_c = bus.wdata1;
        end
    end

    always_comb begin
        wait1_d = wait1_q;
        if (!bus.req1 || gnt1_c) begin
            wait1_d = 4'd0;
        end else if (wait1_q != STARVE_LIM) begin
            wait1_d = wait1_q + 4'd1;
        end
    end

    // One outstanding read at most: a new grant each cycle simply replaces the previous response.
    always_comb begin
        rsp_valid_d = (gnt0_c && !bus.we0) || (gnt1_c && !bus.we1);
        rsp_idx_d   = gnt1_c;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait1_q     <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_idx_q   <= 1'b0;
        end else begin
            wait1_q     <= wait1_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_idx_q   <= rsp_idx_d;
        end
    end

    always_comb begin
        rvalid0_c = rsp_valid_q && !rsp_idx_q;
        rvalid1_c = rsp_valid_q &&  rsp_idx_q;
    end

    assign bus.gnt0           = gnt0_c;
    assign bus.gnt1           = gnt1_c;
    assign bus.operation      = op_c;
    assign bus.memory_address = addr_c;
    assign bus.memory_input   = wdata_c;
    assign bus.rvalid0        = rvalid0_c;
    assign bus.rvalid1        = rvalid1_c;
    assign bus.rdata0         = rvalid0_c ? bus.memory_value : '0;
    assign bus.rdata1         = rvalid1_c ? bus.memory_value : '0;
    assign bus.busy           = gnt0_c | gnt1_c | rvalid0_c | rvalid1_c;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter against a one-cycle-latency memory model.
module tb_mem_arbiter;
    logic clk;
    logic reset;
    int   n_total;
    int   n_bad;
    logic [7:0] mem [256];

    mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    mem_arbiter #(.ADDR_W(8), .DATA_W(8), .STARVE_MAX(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.operation) mem[bus.memory_address] <= bus.memory_input;
        bus.memory_value <= mem[bus.memory_address];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Applies one cycle of requests just after the edge, then waits to mid-cycle for sampling.
    task automatic drive(input logic r0, input logic w0, input logic [7:0] a0, input logic [7:0] d0,
                         input logic r1, input logic w1, input logic [7:0] a1, input logic [7:0] d1);
        @(posedge clk);
        #1;
        bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
        bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
        @(negedge clk);
        $display("txn t=%0t r0=%b w0=%b a0=%h r1=%b w1=%b a1=%h gnt=%b%b rv=%b%b op=%b ma=%h", $time,
                 r0, w0, a0, r1, w1, a1, bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1,
                 bus.operation, bus.memory_address);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'h5A;
        mem[8'h01] = 8'h1E;
        mem[8'h02] = 8'hC3;
        bus.memory_value = 8'h00;

        // Requests present during reset must not leak through.
        reset = 1'b0;
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 8'h55; bus.wdata0 = 8'h77;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h66; bus.wdata1 = 8'h00;
        #3;
        chk("rst_gnt0", {31'b0, bus.gnt0}, 0);
        chk("rst_gnt1", {31'b0, bus.gnt1}, 0);
        chk("rst_op", {31'b0, bus.operation}, 0);
        chk("rst_addr", {24'b0, bus.memory_address}, 0);
        chk("rst_wdata", {24'b0, bus.memory_input}, 0);
        chk("rst_busy", {31'b0, bus.busy}, 0);
        @(posedge clk);
        #1;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        reset = 1'b1;

        // Idle period.
        for (int i = 0; i < 5; i++) begin
            idle();
            chk("idle_op", {31'b0, bus.operation}, 0);
            chk("idle_busy", {31'b0, bus.busy}, 0);
            chk("idle_addr", {24'b0, bus.memory_address}, 0);
        end

        // cpu read of 0x10.
        drive(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("rd0_gnt0", {31'b0, bus.gnt0}, 1);
        chk("rd0_gnt1", {31'b0, bus.gnt1}, 0);
        chk("rd0_op", {31'b0, bus.operation}, 0);
        chk("rd0_addr", {24'b0, bus.memory_address}, 32'h10);
        chk("rd0_busy", {31'b0, bus.busy}, 1);
        idle();
        chk("rd0_rvalid0", {31'b0, bus.rvalid0}, 1);
        chk("rd0_rdata0", {24'b0, bus.rdata0}, 32'h5A);
        chk("rd0_rvalid1", {31'b0, bus.rvalid1}, 0);
        chk("rd0_busy2", {31'b0, bus.busy}, 1);
        idle();
        chk("rd0_rvalid0_off", {31'b0, bus.rvalid0}, 0);
        chk("rd0_rdata0_off", {24'b0, bus.rdata0}, 0);

        // Loader write then read-back of 0x20.
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h20, 8'h33);
        chk("wr1_gnt1", {31'b0, bus.gnt1}, 1);
        chk("wr1_op", {31'b0, bus.operation}, 1);
        chk("wr1_addr", {24'b0, bus.memory_address}, 32'h20);
        chk("wr1_wdata", {24'b0, bus.memory_input}, 32'h33);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00);
        chk("rd1_gnt1", {31'b0, bus.gnt1}, 1);
        chk("rd1_op", {31'b0, bus.operation}, 0);
        chk("rd1_wdata", {24'b0, bus.memory_input}, 0);
        chk("wr1_no_rvalid", {31'b0, bus.rvalid1}, 0);
        idle();
        chk("rd1_rvalid1", {31'b0, bus.rvalid1}, 1);
        chk("rd1_rdata1", {24'b0, bus.rdata1}, 32'h33);
        chk("rd1_rvalid0", {31'b0, bus.rvalid0}, 0);

        // Both requesting continuously: loader wins every fourth cycle.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 8'h02, 8'h00);
            chk("starve_gnt1", {31'b0, bus.gnt1}, (i % 4 == 3) ? 1 : 0);
            chk("starve_gnt0", {31'b0, bus.gnt0}, (i % 4 == 3) ? 0 : 1);
            if (i > 0 && (i % 4 == 0)) begin
                chk("starve_rdata1", {24'b0, bus.rdata1}, 32'hC3);
            end else if (i > 0) begin
                chk("starve_rdata0", {24'b0, bus.rdata0}, 32'h1E);
            end
        end
        idle();

        // Loader drops its request in cycle 2: the wait restarts.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 8'h01, 8'h00, (i != 2), 1'b0, 8'h02, 8'h00);
            chk("drop_gnt1", {31'b0, bus.gnt1}, (i == 6) ? 1 : 0);
        end
        idle();

        // Reset in the cycle after a cpu read grant, with the wait counter part-way up.
        drive(1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'h02, 8'h00);
        chk("pre_rst_gnt0_a", {31'b0, bus.gnt0}, 1);
        drive(1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'h02, 8'h00);
        chk("pre_rst_gnt0_b", {31'b0, bus.gnt0}, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("inrst_rvalid0", {31'b0, bus.rvalid0}, 0);
        chk("inrst_rdata0", {24'b0, bus.rdata0}, 0);
        chk("inrst_gnt0", {31'b0, bus.gnt0}, 0);
        chk("inrst_gnt1", {31'b0, bus.gnt1}, 0);
        chk("inrst_busy", {31'b0, bus.busy}, 0);
        chk("inrst_addr", {24'b0, bus.memory_address}, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_rvalid0", {31'b0, bus.rvalid0}, 0);
        chk("post_rst_gnt0_k0", {31'b0, bus.gnt0}, 1);
        for (int k = 1; k < 4; k++) begin
            drive(1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'h02, 8'h00);
            chk("post_rst_gnt1", {31'b0, bus.gnt1}, (k == 3) ? 1 : 0);
        end
        idle();
        chk("post_rst_rdata1", {24'b0, bus.rdata1}, 32'hC3);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
